// File: rtl/tdm_pkg.sv
// Shared definitions for the 1:8 TDM demultiplexer slice.
// Channel count, slot width and FSM state encoding.
package tdm_pkg;

    localparam int CH    = 8;
    localparam int SEL_W = $clog2(CH);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_1_8_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer.
// master = link driver and word consumer, slave = demux.
interface tdm_demux_1_8_if
    import tdm_pkg::*;
#(
    parameter int CH    = tdm_pkg::CH,
    parameter int SEL_W = $clog2(CH)
);

    logic             din;
    logic             din_valid;
    logic             sync;
    logic [CH-1:0]    ch_strobe;
    logic [SEL_W-1:0] slot;
    logic [CH-1:0]    dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             frame_err;
    logic             overflow;

    modport master (
        output din,
        output din_valid,
        output sync,
        output dout_ready,
        input  ch_strobe,
        input  slot,
        input  dout,
        input  dout_valid,
        input  frame_err,
        input  overflow
    );

    modport slave (
        input  din,
        input  din_valid,
        input  sync,
        input  dout_ready,
        output ch_strobe,
        output slot,
        output dout,
        output dout_valid,
        output frame_err,
        output overflow
    );

endinterface

// File: rtl/tdm_out_buf.sv
// One-entry valid/ready holding register for completed words.
// A word arriving while the held one is unconsumed is dropped.
module tdm_out_buf
    import tdm_pkg::*;
#(
    parameter int W = tdm_pkg::CH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] word,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overflow
);

    logic free;

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (load) begin
                if (free) begin
                    data  <= word;
                    valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdm_demux_1_8.sv
// Time-division serial line back to parallel channels.
// Slot counter, alignment FSM and shift register; output buffered.
module tdm_demux_1_8
    import tdm_pkg::*;
#(
    parameter int CH    = tdm_pkg::CH,
    parameter int SEL_W = $clog2(CH)
) (
    input logic            clk,
    input logic            rst_n,
    tdm_demux_1_8_if.slave bus
);

    state_t           state;
    logic [SEL_W-1:0] slot_q;
    logic [CH-1:0]    shreg;
    logic [CH-1:0]    strobe_q;
    logic             ferr_q;

    logic             accept;
    logic             resync;
    logic             complete;
    logic             misalign;
    logic [SEL_W-1:0] slot_used;
    logic [CH-1:0]    bit_mask;
    logic [CH-1:0]    word;

    assign resync    = bus.din_valid && bus.sync;
    assign accept    = bus.din_valid &&
                       (state == ST_RUN || bus.sync);
    assign slot_used = resync ? '0 : slot_q;
    assign bit_mask  = {{(CH-1){1'b0}}, 1'b1} << slot_used;
    assign misalign  = resync && state == ST_RUN &&
                       slot_q != '0;

    // A sync bit restarts the frame, so the partial word is dropped
    assign word = ((resync ? '0 : shreg) & ~bit_mask) |
                  (bus.din ? bit_mask : '0);

    assign complete = accept &&
                      (slot_used == SEL_W'(CH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HUNT;
            slot_q   <= '0;
            shreg    <= '0;
            strobe_q <= '0;
            ferr_q   <= 1'b0;
        end else begin
            strobe_q <= '0;
            ferr_q   <= 1'b0;
            if (accept) begin
                state    <= ST_RUN;
                slot_q   <= slot_used + SEL_W'(1);
                shreg    <= complete ? '0 : word;
                strobe_q <= bus.din ? bit_mask : '0;
                ferr_q   <= misalign;
            end
        end
    end

    tdm_out_buf #(
        .W (CH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (complete),
        .word     (word),
        .ready    (bus.dout_ready),
        .data     (bus.dout),
        .valid    (bus.dout_valid),
        .overflow (bus.overflow)
    );

    assign bus.ch_strobe = strobe_q;
    assign bus.slot      = slot_q;
    assign bus.frame_err = ferr_q;

endmodule
